// File: rtl/bsg_mcl_fifo_gearbox_array.sv
// Per-channel width gearbox: host words are packed into mc packets (TX), mc packets are buffered and split into host words (RX).
// Latency: TX packet valid 1 cycle after its last word; RX word valid 1 cycle after an enqueue into an empty buffer.
// Backpressure: host_ready_o is low while an assembled packet waits for mc_ready_i; mc_ready_o is low while the RX buffer is full.

module bsg_mcl_fifo_gearbox_array #(
    parameter int num_chan_p   = 2,
    parameter int host_width_p = 32,
    parameter int mc_width_p   = 128,
    parameter int rcv_els_p    = 4,
    parameter int lsw_first_p  = 1
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [num_chan_p-1:0]                       flush_i,

    input  logic [num_chan_p-1:0]                       host_v_i,
    input  logic [num_chan_p*host_width_p-1:0]          host_data_i,
    output logic [num_chan_p-1:0]                       host_ready_o,

    output logic [num_chan_p-1:0]                       mc_v_o,
    output logic [num_chan_p*mc_width_p-1:0]            mc_data_o,
    input  logic [num_chan_p-1:0]                       mc_ready_i,

    input  logic [num_chan_p-1:0]                       mc_v_i,
    input  logic [num_chan_p*mc_width_p-1:0]            mc_data_i,
    output logic [num_chan_p-1:0]                       mc_ready_o,

    output logic [num_chan_p-1:0]                       host_v_o,
    output logic [num_chan_p*host_width_p-1:0]          host_data_o,
    input  logic [num_chan_p-1:0]                       host_yumi_i,

    output logic [num_chan_p*$clog2(rcv_els_p+1)-1:0]   rcv_vacancy_o
);

    // Words per packet and the widths of the counters that walk them.
    localparam int els_lp   = mc_width_p / host_width_p;
    localparam int idx_w_lp = $clog2(els_lp);
    localparam int cnt_w_lp = $clog2(els_lp + 1);
    localparam int vac_w_lp = $clog2(rcv_els_p + 1);
    localparam int ptr_w_lp = $clog2(rcv_els_p);

    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(els_lp - 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(rcv_els_p - 1);
    localparam logic [vac_w_lp-1:0] rcv_els_lp  = vac_w_lp'(rcv_els_p);
    localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(els_lp);

    // RX buffer pointers wrap explicitly so the depth need not be a power of two.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Host word k lands in slice k (LSW first) or in slice els_lp-1-k (MSW first).
    function automatic logic [idx_w_lp-1:0] word_slot(input logic [idx_w_lp-1:0] k);
        return (lsw_first_p != 0) ? k : last_idx_lp - k;
    endfunction

    for (genvar c = 0; c < num_chan_p; c++) begin : g_chan

        // ---------------- TX: host words -> one mc packet ----------------
        logic [cnt_w_lp-1:0]                    tx_cnt_r;
        logic [els_lp-1:0][host_width_p-1:0]    tx_asm_r;
        logic                                   tx_rdy;
        logic                                   tx_vld;
        logic                                   tx_word_acc;
        logic [idx_w_lp-1:0]                    tx_slot;

        assign tx_rdy      = (tx_cnt_r < els_cnt_lp);
        assign tx_vld      = (tx_cnt_r == els_cnt_lp);
        assign tx_word_acc = host_v_i[c] & tx_rdy & ~flush_i[c];
        // tx_cnt_r < els_lp whenever a word is written, so the low bits hold the full index.
        assign tx_slot     = word_slot(tx_cnt_r[idx_w_lp-1:0]);

        // Word counter: flush wins, then packet handoff, then word accept.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                tx_cnt_r <= '0;
            end else if (flush_i[c]) begin
                tx_cnt_r <= '0;
            end else if (tx_vld && mc_ready_i[c]) begin
                tx_cnt_r <= '0;
            end else if (tx_word_acc) begin
                tx_cnt_r <= tx_cnt_r + cnt_w_lp'(1);
            end
        end

        // Assembly register holds data only; its contents are meaningless until tx_vld.
        always_ff @(posedge clk_i) begin
            if (tx_word_acc) begin
                tx_asm_r[tx_slot] <= host_data_i[c*host_width_p +: host_width_p];
            end
        end

        assign host_ready_o[c]                          = tx_rdy;
        assign mc_v_o[c]                                = tx_vld;
        assign mc_data_o[c*mc_width_p +: mc_width_p]    = tx_asm_r;

        // ---------------- RX: packet buffer + word serializer ----------------
        logic [mc_width_p-1:0]                  rx_mem_r [rcv_els_p];
        logic [ptr_w_lp-1:0]                    rx_wr_ptr_r;
        logic [ptr_w_lp-1:0]                    rx_rd_ptr_r;
        logic [vac_w_lp-1:0]                    rx_count_r;
        logic [idx_w_lp-1:0]                    rx_idx_r;
        logic [els_lp-1:0][host_width_p-1:0]    rx_head_dat;
        logic                                   rx_full;
        logic                                   rx_empty;
        logic                                   rx_enq;
        logic                                   rx_yumi;
        logic                                   rx_deq;

        assign rx_full     = (rx_count_r == rcv_els_lp);
        assign rx_empty    = (rx_count_r == '0);
        assign rx_enq      = mc_v_i[c] & ~rx_full & ~flush_i[c];
        // A yumi with nothing offered is ignored here; the assertion below flags it.
        assign rx_yumi     = host_yumi_i[c] & ~rx_empty & ~flush_i[c];
        assign rx_deq      = rx_yumi & (rx_idx_r == last_idx_lp);
        assign rx_head_dat = rx_mem_r[rx_rd_ptr_r];

        // Buffer pointers and occupancy; a simultaneous enqueue and dequeue leave occupancy unchanged.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                rx_wr_ptr_r <= '0;
                rx_rd_ptr_r <= '0;
                rx_count_r  <= '0;
            end else if (flush_i[c]) begin
                rx_wr_ptr_r <= '0;
                rx_rd_ptr_r <= '0;
                rx_count_r  <= '0;
            end else begin
                if (rx_enq) begin
                    rx_wr_ptr_r <= ptr_inc(rx_wr_ptr_r);
                end
                if (rx_deq) begin
                    rx_rd_ptr_r <= ptr_inc(rx_rd_ptr_r);
                end
                if (rx_enq && !rx_deq) begin
                    rx_count_r <= rx_count_r + vac_w_lp'(1);
                end else if (rx_deq && !rx_enq) begin
                    rx_count_r <= rx_count_r - vac_w_lp'(1);
                end
            end
        end

        // Packet storage; written on enqueue only, no reset needed.
        always_ff @(posedge clk_i) begin
            if (rx_enq) begin
                rx_mem_r[rx_wr_ptr_r] <= mc_data_i[c*mc_width_p +: mc_width_p];
            end
        end

        // Word index within the head packet; wraps to 0 as the head is dequeued.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                rx_idx_r <= '0;
            end else if (flush_i[c]) begin
                rx_idx_r <= '0;
            end else if (rx_yumi) begin
                rx_idx_r <= (rx_idx_r == last_idx_lp) ? '0 : rx_idx_r + idx_w_lp'(1);
            end
        end

        assign mc_ready_o[c]                                = ~rx_full;
        assign host_v_o[c]                                  = ~rx_empty;
        assign host_data_o[c*host_width_p +: host_width_p]  = rx_head_dat[word_slot(rx_idx_r)];
        assign rcv_vacancy_o[c*vac_w_lp +: vac_w_lp]        = rcv_els_lp - rx_count_r;

        // Consuming a word that is not being offered is a host-side protocol error.
        a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
            !(host_yumi_i[c] && rx_empty));
    end

endmodule

// File: tb/tb_bsg_mcl_fifo_gearbox_array.sv
// Self-checking bench: directed steps plus a random phase, compared against a queue-based reference model.
// Latency: model advances at each rising edge, outputs are compared on the falling edge.
// Backpressure: model tracks words/packets held and derives ready/valid from queue sizes.

module tb_bsg_mcl_fifo_gearbox_array;

    localparam int NC  = 2;
    localparam int HW  = 32;
    localparam int MW  = 128;
    localparam int RCV = 4;
    localparam int ELS = MW / HW;
    localparam int VW  = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic [NC-1:0]    flush, host_v, mc_ready, mc_v_in, yumi;
    logic [NC*HW-1:0] host_data_in;
    logic [NC*MW-1:0] mc_data_in;

    logic [NC-1:0]    host_ready, mc_v_out, mc_ready_out, host_v_out;
    logic [NC*MW-1:0] mc_data_out;
    logic [NC*HW-1:0] host_data_out;
    logic [NC*VW-1:0] vac;

    logic [NC-1:0]    m_host_ready, m_mc_v_out, m_mc_ready_out, m_host_v_out;
    logic [NC*MW-1:0] m_mc_data_out;
    logic [NC*HW-1:0] m_host_data_out;
    logic [NC*VW-1:0] m_vac;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: words accepted toward the pending packet, and queued RX packets.
    logic [HW-1:0] tx_q [NC][$];
    logic [MW-1:0] rx_q [NC][$];
    int            rx_pos [NC];

    always #5 clk = ~clk;

    bsg_mcl_fifo_gearbox_array #(
        .num_chan_p(NC), .host_width_p(HW), .mc_width_p(MW), .rcv_els_p(RCV), .lsw_first_p(1)
    ) u_dut (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
        .host_v_i(host_v), .host_data_i(host_data_in), .host_ready_o(host_ready),
        .mc_v_o(mc_v_out), .mc_data_o(mc_data_out), .mc_ready_i(mc_ready),
        .mc_v_i(mc_v_in), .mc_data_i(mc_data_in), .mc_ready_o(mc_ready_out),
        .host_v_o(host_v_out), .host_data_o(host_data_out), .host_yumi_i(yumi),
        .rcv_vacancy_o(vac)
    );

    bsg_mcl_fifo_gearbox_array #(
        .num_chan_p(NC), .host_width_p(HW), .mc_width_p(MW), .rcv_els_p(RCV), .lsw_first_p(0)
    ) u_dut_msw (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
        .host_v_i(host_v), .host_data_i(host_data_in), .host_ready_o(m_host_ready),
        .mc_v_o(m_mc_v_out), .mc_data_o(m_mc_data_out), .mc_ready_i(mc_ready),
        .mc_v_i(mc_v_in), .mc_data_i(mc_data_in), .mc_ready_o(m_mc_ready_out),
        .host_v_o(m_host_v_out), .host_data_o(m_host_data_out), .host_yumi_i(yumi),
        .rcv_vacancy_o(m_vac)
    );

    task automatic chk(input string tag, input int ch, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s ch%0d observed=%h expected=%h", tag, ch, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            tx_q[c].delete();
            rx_q[c].delete();
            rx_pos[c] = 0;
        end
    endtask

    function automatic logic [MW-1:0] tx_packet(input int c, input bit msw);
        logic [MW-1:0] p = '0;
        for (int k = 0; k < tx_q[c].size(); k++)
            p[(msw ? ELS-1-k : k)*HW +: HW] = tx_q[c][k];
        return p;
    endfunction

    function automatic logic [HW-1:0] rx_word(input int c, input bit msw);
        logic [MW-1:0] h = rx_q[c][0];
        return h[(msw ? ELS-1-rx_pos[c] : rx_pos[c])*HW +: HW];
    endfunction

    // One clock edge of the reference model, using the inputs held across that edge.
    task automatic model_step();
        for (int c = 0; c < NC; c++) begin
            if (flush[c]) begin
                tx_q[c].delete();
                rx_q[c].delete();
                rx_pos[c] = 0;
            end else begin
                int txn = tx_q[c].size();
                int rxn = rx_q[c].size();
                if (txn == ELS && mc_ready[c])
                    tx_q[c].delete();
                else if (txn < ELS && host_v[c])
                    tx_q[c].push_back(host_data_in[c*HW +: HW]);
                if (yumi[c] && rxn > 0) begin
                    rx_pos[c]++;
                    if (rx_pos[c] == ELS) begin
                        void'(rx_q[c].pop_front());
                        rx_pos[c] = 0;
                    end
                end
                if (mc_v_in[c] && rxn < RCV)
                    rx_q[c].push_back(mc_data_in[c*MW +: MW]);
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NC; c++) begin
            chk("host_ready", c, MW'(host_ready[c]), MW'(tx_q[c].size() < ELS));
            chk("mc_v", c, MW'(mc_v_out[c]), MW'(tx_q[c].size() == ELS));
            if (tx_q[c].size() == ELS) begin
                chk("mc_data_lsw", c, mc_data_out[c*MW +: MW], tx_packet(c, 1'b0));
                chk("mc_data_msw", c, m_mc_data_out[c*MW +: MW], tx_packet(c, 1'b1));
            end
            chk("mc_ready", c, MW'(mc_ready_out[c]), MW'(rx_q[c].size() < RCV));
            chk("host_v", c, MW'(host_v_out[c]), MW'(rx_q[c].size() > 0));
            if (rx_q[c].size() > 0) begin
                chk("host_data_lsw", c, MW'(host_data_out[c*HW +: HW]), MW'(rx_word(c, 1'b0)));
                chk("host_data_msw", c, MW'(m_host_data_out[c*HW +: HW]), MW'(rx_word(c, 1'b1)));
            end
            chk("vacancy", c, MW'(vac[c*VW +: VW]), MW'(RCV - rx_q[c].size()));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        flush = '0; host_v = '0; mc_ready = '0; mc_v_in = '0; yumi = '0;
        host_data_in = '0; mc_data_in = '0;
    endtask

    function automatic logic [MW-1:0] rand_pkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        idle();
        model_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_host_ready", 0, MW'(host_ready), MW'(2'b11));
        chk("rst_mc_v", 0, MW'(mc_v_out), MW'(2'b00));
        chk("rst_mc_ready", 0, MW'(mc_ready_out), MW'(2'b11));
        chk("rst_host_v", 0, MW'(host_v_out), MW'(2'b00));
        chk("rst_vacancy", 0, MW'(vac), MW'(6'b100_100));
        @(negedge clk);
        reset_n = 1'b1;
        check_all();

        // Channel 0 TX: four words, packet held until mc_ready_i.
        for (int k = 0; k < ELS; k++) begin
            host_v[0] = 1'b1;
            host_data_in[HW-1:0] = 32'h11111111 * (k + 1);
            cycle();
        end
        chk("tx_pkt_lsw", 0, mc_data_out[MW-1:0], 128'h44444444_33333333_22222222_11111111);
        chk("tx_pkt_msw", 0, m_mc_data_out[MW-1:0], 128'h11111111_22222222_33333333_44444444);
        host_data_in[HW-1:0] = 32'h55555555;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("tx_hold_ready", 0, MW'(host_ready[0]), MW'(1'b0));
        end
        host_v[0] = 1'b0;
        mc_ready[0] = 1'b1;
        cycle();
        chk("tx_release_v", 0, MW'(mc_v_out[0]), MW'(1'b0));
        idle();

        // Channel 0 RX fill without consumption.
        chk("rx_vac_empty", 0, MW'(vac[VW-1:0]), MW'(RCV));
        for (int i = 0; i < RCV; i++) begin
            mc_v_in[0] = 1'b1;
            mc_data_in[MW-1:0] = rand_pkt();
            cycle();
            chk("rx_vac_fill", 0, MW'(vac[VW-1:0]), MW'(RCV - 1 - i));
        end
        chk("rx_full_ready", 0, MW'(mc_ready_out[0]), MW'(1'b0));
        // A packet offered while full is dropped; one yumi does not free space.
        mc_data_in[MW-1:0] = rand_pkt();
        yumi[0] = 1'b1;
        cycle();
        chk("rx_vac_one_yumi", 0, MW'(vac[VW-1:0]), MW'(0));
        mc_v_in[0] = 1'b0;
        for (int i = 0; i < ELS - 1; i++) cycle();
        chk("rx_vac_head_done", 0, MW'(vac[VW-1:0]), MW'(1));
        chk("rx_ready_after", 0, MW'(mc_ready_out[0]), MW'(1'b1));

        // Drain one more packet to occupancy 2, then enqueue on the final-word yumi.
        for (int i = 0; i < ELS; i++) cycle();
        chk("rx_vac_occ2", 0, MW'(vac[VW-1:0]), MW'(2));
        for (int i = 0; i < ELS - 1; i++) cycle();
        mc_v_in[0] = 1'b1;
        mc_data_in[MW-1:0] = rand_pkt();
        cycle();
        chk("rx_vac_simul", 0, MW'(vac[VW-1:0]), MW'(2));
        idle();

        // Channel 1: three TX words and two RX packets, then flush with a same-cycle packet.
        for (int i = 0; i < 3; i++) begin
            host_v[1] = 1'b1;
            host_data_in[HW +: HW] = $urandom;
            mc_v_in[1] = (i < 2);
            mc_data_in[MW +: MW] = rand_pkt();
            cycle();
        end
        idle();
        flush[1] = 1'b1;
        mc_v_in[1] = 1'b1;
        mc_data_in[MW +: MW] = rand_pkt();
        host_v = 2'b11;
        host_data_in = {$urandom, $urandom};
        yumi[0] = host_v_out[0];
        cycle();
        chk("flush_ready", 1, MW'(host_ready[1]), MW'(1'b1));
        chk("flush_host_v", 1, MW'(host_v_out[1]), MW'(1'b0));
        chk("flush_vac", 1, MW'(vac[VW +: VW]), MW'(RCV));
        idle();

        // Random traffic on both channels with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NC; c++) begin
                flush[c]    = ($urandom_range(0, 39) == 0);
                host_v[c]   = $urandom_range(0, 1) == 1;
                host_data_in[c*HW +: HW] = $urandom;
                mc_ready[c] = $urandom_range(0, 2) != 0;
                mc_v_in[c]  = $urandom_range(0, 2) == 0;
                mc_data_in[c*MW +: MW] = rand_pkt();
                yumi[c]     = (rx_q[c].size() > 0) && ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        idle();

        // Reset in the middle of a TX packet and with RX data buffered.
        for (int i = 0; i < 2; i++) begin
            host_v[0] = 1'b1;
            host_data_in[HW-1:0] = $urandom;
            mc_v_in[1] = 1'b1;
            mc_data_in[MW +: MW] = rand_pkt();
            cycle();
        end
        idle();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_host_ready", 0, MW'(host_ready), MW'(2'b11));
        chk("arst_mc_v", 0, MW'(mc_v_out), MW'(2'b00));
        chk("arst_mc_ready", 0, MW'(mc_ready_out), MW'(2'b11));
        chk("arst_host_v", 0, MW'(host_v_out), MW'(2'b00));
        chk("arst_vacancy", 0, MW'(vac), MW'(6'b100_100));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
        for (int k = 0; k < ELS; k++) begin
            host_v[0] = 1'b1;
            host_data_in[HW-1:0] = 32'hA0000001 + k;
            cycle();
        end
        chk("post_rst_pkt", 0, mc_data_out[MW-1:0], 128'hA0000004_A0000003_A0000002_A0000001);
        host_v[0] = 1'b0;
        mc_ready[0] = 1'b1;
        cycle();
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
